// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } gcd_state_e;

  localparam int ALGO_SUB = 0;
  localparam int ALGO_BIN = 1;

  // Width of the common power-of-two shift count for a given operand width.
  function automatic int k_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/gcd_engine_if.sv
// Operand/result handshake bundle for gcd_engine; cycles_o exists only with GCD_CYCLE_CNT_EN.
// Handshake: operands transfer on an edge where valid_i && ready_o; the result transfers
// on an edge where valid_o && ready_i; a held valid is never withdrawn by the engine.
interface gcd_engine_if
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [WIDTH-1:0] gcd_o;
  logic             valid_o;
  logic             ready_i;
  logic             busy_o;
`ifdef GCD_CYCLE_CNT_EN
  logic [CNT_W-1:0] cycles_o;
`endif
  gcd_state_e       state_dbg;

  modport slave (
    input  valid_i, a_i, b_i, ready_i,
    output ready_o, gcd_o, valid_o, busy_o,
`ifdef GCD_CYCLE_CNT_EN
    cycles_o,
`endif
    state_dbg
  );

  modport master (
    output valid_i, a_i, b_i, ready_i,
    input  ready_o, gcd_o, valid_o, busy_o,
`ifdef GCD_CYCLE_CNT_EN
    cycles_o,
`endif
    state_dbg
  );

endinterface

// File: rtl/gcd_step_unit.sv
// One combinational GCD iteration: subtractive Euclid (ALGO_SUB) or binary Stein (ALGO_BIN).
module gcd_step_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ALGO  = ALGO_SUB
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             k_inc_o,
  output logic             term_o
);

  always_comb begin
    a_o     = a_i;
    b_o     = b_i;
    k_inc_o = 1'b0;
    term_o  = 1'b0;
    if ((a_i == b_i) || (a_i == '0) || (b_i == '0)) begin
      term_o = 1'b1;
    end else if (ALGO == ALGO_BIN) begin
      // Shared factors of two are stripped together and restored from k at the end.
      if (!a_i[0] && !b_i[0]) begin
        a_o     = a_i >> 1;
        b_o     = b_i >> 1;
        k_inc_o = 1'b1;
      end else if (!a_i[0]) begin
        a_o = a_i >> 1;
      end else if (!b_i[0]) begin
        b_o = b_i >> 1;
      end else if (a_i > b_i) begin
        a_o = a_i - b_i;
      end else begin
        b_o = b_i - a_i;
      end
    end else begin
      if (a_i > b_i) begin
        a_o = a_i - b_i;
      end else begin
        b_o = b_i - a_i;
      end
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD engine with valid/ready operand and result handshakes.
// Optional COMPUTE-cycle counter on cycles_o is compiled in with GCD_CYCLE_CNT_EN.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ALGO  = ALGO_SUB,
  parameter int CNT_W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  gcd_engine_if.slave  bus
);

  localparam int KW = k_width(WIDTH);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, gcd_q;
  logic [WIDTH-1:0] a_nxt, b_nxt;
  logic [WIDTH-1:0] result;
  logic [KW-1:0]    k_q;
  logic             k_inc, term;
  logic             accept, finish, release_res;

  gcd_step_unit #(
    .WIDTH (WIDTH),
    .ALGO  (ALGO)
  ) u_step (
    .a_i     (a_q),
    .b_i     (b_q),
    .a_o     (a_nxt),
    .b_o     (b_nxt),
    .k_inc_o (k_inc),
    .term_o  (term)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    finish      = 1'b0;
    release_res = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          accept  = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (term) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.ready_i) begin
          release_res = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a|b is the surviving nonzero operand (or the common value when a==b).
  always_comb begin
    result = a_q | b_q;
    if (ALGO == ALGO_BIN) result = result << k_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      k_q   <= '0;
      gcd_q <= '0;
    end else if (accept) begin
      a_q <= bus.a_i;
      b_q <= bus.b_i;
      k_q <= '0;
    end else if (state_q == COMPUTE) begin
      if (finish) begin
        gcd_q <= result;
      end else begin
        a_q <= a_nxt;
        b_q <= b_nxt;
        k_q <= k_q + KW'(k_inc);
      end
    end else if (release_res) begin
      gcd_q <= '0;
    end
  end

`ifdef GCD_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || accept) begin
      cnt_q <= '0;
    end else if ((state_q == COMPUTE) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.cycles_o = (state_q == DONE) ? cnt_q : '0;
`endif

  assign bus.ready_o   = (state_q == IDLE);
  assign bus.busy_o    = (state_q == COMPUTE);
  assign bus.valid_o   = (state_q == DONE);
  assign bus.gcd_o     = (state_q == DONE) ? gcd_q : '0;
  assign bus.state_dbg = state_q;

endmodule
